alu_req_arbiter: RTL

Shares one ALU_32_bit instance between two requesters, handing each requester whole operations. Requesters use a valid/ready handshake. Arbitration is round-robin. The block drives the ALU operands and opcode, captures single-cycle results after one cycle, and waits on alu_done for multiply (1000) and divide (1001). Every result goes out on one response channel, tagged with the requester ID.

---
 rtl/alu_req_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a single shared ALU: whole operations,
// one in flight, results returned on a single tagged response channel.
module alu_req_arbiter #(
  parameter int N       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [7:0]     req_opcode,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic [N-1:0]   rsp_remainder,
  output logic [2:0]     rsp_flags,
  output logic           rsp_err,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alu_opcode,
  input  logic [N-1:0]   alu_result,
  input  logic [N-1:0]   alu_remainder,
  input  logic           alu_carry_out,
  input  logic           alu_zero,
  input  logic           alu_overflow,
  input  logic           alu_done
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    WAIT_MC = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          rr_ptr_r;
  logic [CW-1:0] cnt_r;

  logic          grant_s;
  logic          accept_s;
  logic [N-1:0]  sel_a_s;
  logic [N-1:0]  sel_b_s;
  logic [3:0]    sel_op_s;
  logic          op_multi_s;
  logic          op_illegal_s;
  logic          done_ok_s;
  logic          timeout_s;

  // Round-robin pick: the pointer's requester if valid, otherwise the other one.
  always_comb begin
    if (req_valid[rr_ptr_r]) begin
      grant_s = rr_ptr_r;
    end else begin
      grant_s = ~rr_ptr_r;
    end
  end

  // Gating with rst_n keeps req_ready low while reset is held.
  assign accept_s     = rst_n && (state_r == IDLE) && (|req_valid);
  assign req_ready    = accept_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
  assign sel_a_s      = grant_s ? req_a[2*N-1:N] : req_a[N-1:0];
  assign sel_b_s      = grant_s ? req_b[2*N-1:N] : req_b[N-1:0];
  assign sel_op_s     = grant_s ? req_opcode[7:4] : req_opcode[3:0];
  assign op_multi_s   = (sel_op_s == 4'b1000) || (sel_op_s == 4'b1001);
  assign op_illegal_s = (sel_op_s >= 4'b1010);
  // A done seen on the first wait cycle may belong to the previous operation.
  assign done_ok_s    = (cnt_r != '0) && alu_done;
  assign timeout_s    = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (op_illegal_s) begin
            state_s = RESP;
          end else if (op_multi_s) begin
            state_s = WAIT_MC;
          end else begin
            state_s = EXEC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
      end
      WAIT_MC: begin
        if (done_ok_s || timeout_s) begin
          state_s = RESP;
        end else begin
          state_s = WAIT_MC;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // ALU operand/opcode registers: loaded only on a legal accept, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 4'b0000;
    end else if (accept_s && !op_illegal_s) begin
      alu_a      <= sel_a_s;
      alu_b      <= sel_b_s;
      alu_opcode <= sel_op_s;
    end
  end

  // Multi-cycle wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= '0;
    end else if ((state_r == WAIT_MC) && !done_ok_s && !timeout_s) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Fairness pointer: after a response, favour the requester that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= 1'b0;
    end else if ((state_r == RESP) && rsp_ready) begin
      rr_ptr_r <= ~rsp_id;
    end
  end

  // Response channel: filled on completion, held stable until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_flags     <= 3'b000;
      rsp_err       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            rsp_id <= grant_s;
            if (op_illegal_s) begin
              rsp_valid     <= 1'b1;
              rsp_err       <= 1'b1;
              rsp_result    <= '0;
              rsp_remainder <= '0;
              rsp_flags     <= 3'b000;
            end
          end
        end
        EXEC: begin
          rsp_valid     <= 1'b1;
          rsp_err       <= 1'b0;
          rsp_result    <= alu_result;
          rsp_remainder <= alu_remainder;
          rsp_flags     <= {alu_carry_out, alu_zero, alu_overflow};
        end
        WAIT_MC: begin
          if (done_ok_s) begin
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b0;
            rsp_result    <= alu_result;
            rsp_remainder <= alu_remainder;
            rsp_flags     <= {alu_carry_out, alu_zero, alu_overflow};
          end else if (timeout_s) begin
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_result    <= '0;
            rsp_remainder <= '0;
            rsp_flags     <= 3'b000;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
